// File: rtl/rv_pkg.sv
// Shared RV32I sequencer definitions: state encoding, NOP, default width, opcode classes.
package rv_pkg;

   localparam int unsigned XlenDefault = 32;

   // addi x0, x0, 0
   localparam logic [31:0] Nop = 32'h0000_0013;

   // Major opcode classes shared with the decoder
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;

   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StExec,
      StMem,
      StWb,
      StHalt
   } seq_state_e;

endpackage

// File: rtl/seq_pc.sv
// Program counter: reset-vector load, next-PC select and branch-target alignment check.
module seq_pc
   import rv_pkg::*;
#(
   parameter int unsigned    XLEN     = XlenDefault,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            adv_i,
   input  logic            branch_taken_i,
   input  logic [XLEN-1:0] branch_target_i,
   output logic [XLEN-1:0] pc_o,
   output logic            misaligned_o
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;

   // Taken targets must be word aligned; a misaligned one stops the core
   always_comb begin
      misaligned_o = branch_taken_i && (branch_target_i[1:0] != 2'b00);
      pc_d         = branch_taken_i ? branch_target_i : pc_q + XLEN'(4);
   end

   // PC only moves when an instruction retires
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q <= RESET_PC;
      end else if (adv_i) begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/write-back sequencer for the RV32I core.
module mc_sequencer
   import rv_pkg::*;
#(
   parameter int unsigned     XLEN     = XlenDefault,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     CNT_W    = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   output logic             imem_req_o,
   output logic [XLEN-1:0]  imem_addr_o,
   input  logic             imem_ready_i,
   input  logic [31:0]      imem_rdata_i,
   output logic [31:0]      instr_o,
   input  logic             dec_w_enable_i,
   input  logic             dec_is_load_i,
   input  logic             dec_is_store_i,
   input  logic             dec_illegal_i,
   input  logic [XLEN-1:0]  alu_y_i,
   input  logic             branch_taken_i,
   input  logic [XLEN-1:0]  branch_target_i,
   input  logic [XLEN-1:0]  rs2_data_i,
   output logic             dmem_req_o,
   output logic             dmem_we_o,
   output logic [XLEN-1:0]  dmem_addr_o,
   output logic [XLEN-1:0]  dmem_wdata_o,
   input  logic             dmem_ready_i,
   input  logic [XLEN-1:0]  dmem_rdata_i,
   output logic             rf_we_o,
   output logic [XLEN-1:0]  rf_wdata_o,
   output logic [XLEN-1:0]  pc_o,
   output logic             retire_o,
   output logic [CNT_W-1:0] retired_o,
   output logic             halted_o
);

   seq_state_e       state_q;
   logic [31:0]      instr_q;
   logic [XLEN-1:0]  result_q;
   logic [CNT_W-1:0] retired_q;
   logic             misaligned;
   logic             wb_ok;

   assign wb_ok = (state_q == StWb) && !misaligned;

   seq_pc #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_seq_pc (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .adv_i           (wb_ok),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .pc_o            (pc_o),
      .misaligned_o    (misaligned)
   );

   // Per-instruction state machine with instruction, result and retire-count registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StFetch;
         instr_q   <= Nop;
         result_q  <= '0;
         retired_q <= '0;
      end else begin
         case (state_q)
            StFetch: begin
               if (imem_ready_i) begin
                  instr_q <= imem_rdata_i;
                  state_q <= StDecode;
               end
            end
            StDecode: state_q <= dec_illegal_i ? StHalt : StExec;
            StExec: begin
               result_q <= alu_y_i;
               state_q  <= (dec_is_load_i || dec_is_store_i) ? StMem : StWb;
            end
            StMem: begin
               if (dmem_ready_i) begin
                  if (dec_is_load_i) begin
                     result_q <= dmem_rdata_i;
                  end
                  state_q <= StWb;
               end
            end
            StWb: begin
               if (misaligned) begin
                  state_q <= StHalt;
               end else begin
                  retired_q <= retired_q + CNT_W'(1);
                  state_q   <= StFetch;
               end
            end
            StHalt:  state_q <= StHalt;
            default: state_q <= StHalt;
         endcase
      end
   end

   // Handshake and write-back controls decoded from state; reset masks the fetch request
   always_comb begin
      imem_req_o   = (state_q == StFetch) && rst_ni;
      imem_addr_o  = pc_o;
      dmem_req_o   = (state_q == StMem);
      dmem_we_o    = (state_q == StMem) && dec_is_store_i;
      dmem_addr_o  = result_q;
      dmem_wdata_o = rs2_data_i;
      rf_we_o      = wb_ok && dec_w_enable_i && !dec_is_store_i;
      rf_wdata_o   = result_q;
      retire_o     = wb_ok;
      halted_o     = (state_q == StHalt);
   end

   assign instr_o   = instr_q;
   assign retired_o = retired_q;

endmodule
